// File: rtl/ring_out_arbiter.sv
// ring_out_arbiter
//
// Shares one ring output link among NUM_REQ packet sources. Each cycle one
// source whose vc bit matches the current ring polarity is granted in
// round-robin order. Its packet has the hop field consumed by one and is
// registered onto the output link under a valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   req_valid  per-requester packet present
//   req_data   requester i packet at req_data[DATA_W*i +: DATA_W]
//   req_ready  one-hot grant (combinational)
//   out_valid  output register holds a packet
//   out_data   registered output packet
//   out_ready  downstream accepts out_data
//   polarity   current ring polarity (VC phase), toggles every cycle
module ring_out_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   input  logic                        out_ready,
   output logic                        polarity
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Packet field positions
   localparam int VC_BIT = 63;
   localparam int HOP_LO = 48;
   localparam int HOP_HI = 55;

   // Consume one hop: logical shift right of the hop field only.
   function automatic logic [DATA_W-1:0] rewrite_hop(input logic [DATA_W-1:0] pkt);
      logic [DATA_W-1:0] res;
      res                = pkt;
      res[HOP_HI:HOP_LO] = pkt[HOP_HI:HOP_LO] >> 1;
      return res;
   endfunction

   logic                 pol_p0;
   logic [PTR_W-1:0]     ptr_p0;
   logic                 vld_p0;
   logic [DATA_W-1:0]    data_p0;

   logic [NUM_REQ-1:0]   elig;
   logic                 load;
   logic                 found;
   logic                 grant_vld;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     scan_idx;
   logic [DATA_W-1:0]    sel_data;

   assign load = !vld_p0 || out_ready;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] && (req_data[DATA_W*i + VC_BIT] == pol_p0);
      end
   end

   // Round-robin scan starting at ptr; index arithmetic wraps naturally
   // because NUM_REQ is a power of two.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = ptr_p0 + PTR_W'(k);
         if (!found && elig[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // Grant is suppressed while the output register is stalled and while
   // reset is asserted.
   assign grant_vld = found && load && rst;

   always_comb begin
      req_ready = '0;
      if (grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign sel_data = req_data[DATA_W*int'(grant_idx) +: DATA_W];

   // ---- stage p0: output register, pointer and polarity ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pol_p0  <= 1'b0;
         ptr_p0  <= '0;
         vld_p0  <= 1'b0;
         data_p0 <= '0;
      end else begin
         pol_p0 <= ~pol_p0;
         if (grant_vld) begin
            vld_p0  <= 1'b1;
            data_p0 <= rewrite_hop(sel_data);
            ptr_p0  <= grant_idx + PTR_W'(1);
         end else if (load) begin
            vld_p0  <= 1'b0;
         end
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign polarity  = pol_p0;

endmodule

// File: tb/tb_ring_out_arbiter.sv
module tb_ring_out_arbiter;
   localparam int N = 4;
   localparam int W = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data = '0;
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_ready = 1'b1;
   logic             polarity;

   ring_out_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .polarity(polarity)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   bit           mpol;
   int           mptr;
   bit           drop_on_grant;
   int           last_g;
   int           last_cnt;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_pkt(input bit vc, input bit dir, input logic [7:0] hop,
                                            input logic [31:0] pay);
      return {vc, dir, 6'h2a, hop, 16'hbeef, pay};
   endfunction

   function automatic logic [W-1:0] hop_out(input logic [W-1:0] p);
      logic [7:0] h;
      h = p[55:48];
      return {p[63:56], 1'b0, h[7:1], p[47:0]};
   endfunction

   task automatic set_req(input int i, input logic [W-1:0] p);
      req_data[W*i +: W] = p;
   endtask

   // One clock cycle: checks at the falling edge against the model, then the
   // model advances on the rising edge. Returns at rising edge + 1.
   task automatic cycle();
      logic [N-1:0] exp_rdy;
      int           g;
      bit           load;
      @(negedge clk);
      load = (exp_q.size() == 0) || out_ready;
      g = -1;
      if (load) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (g < 0 && req_valid[idx] && req_data[W*idx + 63] == mpol) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
      check_val("polarity", 64'(polarity), 64'(mpol));
      check_val("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check_val("out_data", out_data, exp_q[0]);
      last_g   = -1;
      last_cnt = 0;
      for (int k = 0; k < N; k++) if (req_ready[k]) begin last_g = k; last_cnt++; end
      @(posedge clk);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
         exp_q.push_back(hop_out(req_data[W*g +: W]));
         mptr = (g + 1) % N;
      end
      mpol = ~mpol;
      #1;
      if (drop_on_grant && g >= 0) req_valid[g] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_data", out_data, 64'd0);
      check_val("rst_polarity", 64'(polarity), 64'd0);
      check_val("rst_req_ready", 64'(req_ready), 64'd0);
      exp_q.delete();
      mpol = 1'b0;
      mptr = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic align_pol0();
      if (mpol != 1'b0) cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq3[4];
      int k4;
      logic [W-1:0] p;
      drop_on_grant = 1'b1;
      #2;
      do_reset();

      // Single packet in a polarity-0 cycle
      align_pol0();
      set_req(0, {1'b0, 1'b0, 6'b0, 8'hff, 16'b0, 32'hffff_fff0});
      req_valid = 4'b0001;
      cycle();
      check_val("t2_grant", 64'(last_g), 64'd0);
      check_val("t2_out_valid", 64'(out_valid), 64'd1);
      check_val("t2_hop", 64'(out_data[55:48]), 64'h7f);
      check_val("t2_payload", 64'(out_data[31:0]), 64'hffff_fff0);
      cycle();

      // Polarity interleave from ptr=0, polarity 0
      do_reset();
      set_req(0, mk_pkt(1'b0, 1'b0, 8'h20, 32'h0000_0a00));
      set_req(1, mk_pkt(1'b0, 1'b1, 8'h21, 32'h0000_0a01));
      set_req(2, mk_pkt(1'b1, 1'b0, 8'h22, 32'h0000_0a02));
      set_req(3, mk_pkt(1'b1, 1'b1, 8'h23, 32'h0000_0a03));
      req_valid = 4'b1111;
      out_ready = 1'b1;
      seq3 = '{0, 2, 1, 3};
      for (int j = 0; j < 4; j++) begin
         cycle();
         check_val("t3_grant", 64'(last_g), 64'(seq3[j]));
         check_val("t3_out_valid", 64'(out_valid), 64'd1);
      end
      cycle();

      // Round-robin wrap, persistent vc=0 sources
      drop_on_grant = 1'b0;
      req_valid = '0;
      align_pol0();
      for (int i = 0; i < N; i++) set_req(i, mk_pkt(1'b0, 1'b0, 8'h40 + 8'(i), 32'h1000 + i));
      req_valid = 4'b1111;
      k4 = 0;
      for (int j = 0; j < 10; j++) begin
         cycle();
         if (j % 2 == 0) begin
            check_val("t4_grant", 64'(last_g), 64'(k4 % N));
            check_val("t4_out_valid_hi", 64'(out_valid), 64'd1);
            k4++;
         end else begin
            check_val("t4_nogrant", 64'(last_g), 64'hffff_ffff_ffff_ffff);
            check_val("t4_out_valid_lo", 64'(out_valid), 64'd0);
         end
      end

      // Backpressure
      drop_on_grant = 1'b1;
      req_valid = '0;
      cycle();
      align_pol0();
      p = mk_pkt(1'b0, 1'b1, 8'h10, 32'h5555_aaaa);
      set_req(0, p);
      req_valid = 4'b0001;
      cycle();
      out_ready = 1'b0;
      set_req(0, mk_pkt(1'b0, 1'b0, 8'h30, 32'h0000_b000));
      set_req(1, mk_pkt(1'b0, 1'b0, 8'h31, 32'h0000_b001));
      set_req(2, mk_pkt(1'b1, 1'b0, 8'h32, 32'h0000_b002));
      set_req(3, mk_pkt(1'b1, 1'b0, 8'h33, 32'h0000_b003));
      req_valid = 4'b1111;
      for (int j = 0; j < 3; j++) begin
         cycle();
         check_val("t5_hold_data", out_data, mk_pkt(1'b0, 1'b1, 8'h08, 32'h5555_aaaa));
         check_val("t5_no_grant", 64'(last_cnt), 64'd0);
      end
      out_ready = 1'b1;
      cycle();
      check_val("t5_one_grant", 64'(last_cnt), 64'd1);
      check_val("t5_new_valid", 64'(out_valid), 64'd1);
      req_valid = '0;
      cycle();

      // Hop boundary
      align_pol0();
      set_req(2, {1'b0, 1'b1, 6'h15, 8'h01, 16'h1234, 32'hdead_beef});
      req_valid = 4'b0100;
      cycle();
      check_val("t6_hop01", out_data, {1'b0, 1'b1, 6'h15, 8'h00, 16'h1234, 32'hdead_beef});
      set_req(1, {1'b1, 1'b0, 6'h3f, 8'h00, 16'hffff, 32'h0123_4567});
      req_valid = 4'b0010;
      cycle();
      check_val("t6_hop00", out_data, {1'b1, 1'b0, 6'h3f, 8'h00, 16'hffff, 32'h0123_4567});
      cycle();

      // Reset mid-traffic, then lowest eligible index wins
      drop_on_grant = 1'b0;
      align_pol0();
      set_req(0, mk_pkt(1'b0, 1'b0, 8'h50, 32'h0000_c000));
      set_req(1, mk_pkt(1'b0, 1'b0, 8'h51, 32'h0000_c001));
      req_valid = 4'b0011;
      for (int j = 0; j < 4; j++) cycle();
      out_ready = 1'b0;
      cycle();
      do_reset();
      out_ready = 1'b1;
      set_req(2, mk_pkt(1'b0, 1'b0, 8'h52, 32'h0000_c002));
      set_req(3, mk_pkt(1'b0, 1'b0, 8'h53, 32'h0000_c003));
      req_valid = 4'b1110;
      cycle();
      check_val("t1_first_grant", 64'(last_g), 64'd1);
      req_valid = '0;
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
